// File: rtl/uc_slot_scheduler.sv
// Shares one CNT_W-bit up-counter between N requesters with round-robin grants.
// Build option: define USS_FIXED_PRIO_EN for fixed lowest-index-wins arbitration.
module uc_slot_scheduler #(
  parameter int unsigned N     = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic               uss_clk,
  input  logic               uss_rst_n,
  input  logic [N-1:0]       uss_req,
  input  logic [N*CNT_W-1:0] uss_len,
  output logic [N-1:0]       uss_gnt,
  output logic               uss_busy,
  output logic [CNT_W-1:0]   uss_cnt,
  output logic [N-1:0]       uss_done,
  output logic               uss_abort
);

  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [N-1:0]       r_gnt;
  logic [N-1:0]       r_done;
  logic               r_busy;
  logic               r_abort;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_len;
  logic [PTR_W-1:0]   r_win;
  logic [PTR_W-1:0]   w_ptr;
  logic [PTR_W-1:0]   w_cand;
  logic [PTR_W-1:0]   w_win_idx;
  logic               w_found;

`ifdef USS_FIXED_PRIO_EN
  assign w_ptr = '0;
`else
  logic [PTR_W-1:0] r_ptr;

  // Next search starts just after the requester that was last served.
  always_ff @(posedge uss_clk or negedge uss_rst_n) begin
    if (!uss_rst_n) begin
      r_ptr <= '0;
    end else if (r_state == S_DONE) begin
      r_ptr <= (r_win == PTR_W'(N - 1)) ? '0 : r_win + 1'b1;
    end
  end

  assign w_ptr = r_ptr;
`endif

  // First set request searching upward from the pointer, wrapping.
  always_comb begin
    w_found   = 1'b0;
    w_win_idx = '0;
    w_cand    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_cand = PTR_W'((32'(w_ptr) + k) % N);
      if (!w_found && uss_req[w_cand]) begin
        w_found   = 1'b1;
        w_win_idx = w_cand;
      end
    end
  end

  always_ff @(posedge uss_clk or negedge uss_rst_n) begin
    if (!uss_rst_n) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_done  <= '0;
      r_abort <= 1'b0;
      r_len   <= '0;
      r_win   <= '0;
    end else begin
      r_done  <= '0;
      r_abort <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_win   <= w_win_idx;
            r_gnt   <= N'(1) << w_win_idx;
            r_len   <= uss_len[32'(w_win_idx) * CNT_W +: CNT_W];
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          // Withdrawal wins over a coincident terminal count.
          if (!uss_req[r_win]) begin
            r_abort <= 1'b1;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_DONE;
          end else if (r_cnt == r_len) begin
            r_done  <= r_gnt;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign uss_gnt   = r_gnt;
  assign uss_busy  = r_busy;
  assign uss_cnt   = r_cnt;
  assign uss_done  = r_done;
  assign uss_abort = r_abort;

endmodule

// File: tb/tb_uc_slot_scheduler.sv
// Self-checking bench for uc_slot_scheduler against a slot-level behavioural model.
module tb_uc_slot_scheduler;

  localparam int unsigned N     = 4;
  localparam int unsigned CNT_W = 3;

  logic               clk;
  logic               rst_n;
  logic [N-1:0]       req;
  logic [N*CNT_W-1:0] len;
  logic [N-1:0]       gnt;
  logic               busy;
  logic [CNT_W-1:0]   cnt;
  logic [N-1:0]       done;
  logic               abort;

  int total;
  int bad;
  int ptr;

  uc_slot_scheduler #(.N(N), .CNT_W(CNT_W)) dut (
    .uss_clk  (clk),
    .uss_rst_n(rst_n),
    .uss_req  (req),
    .uss_len  (len),
    .uss_gnt  (gnt),
    .uss_busy (busy),
    .uss_cnt  (cnt),
    .uss_done (done),
    .uss_abort(abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model arbitration: first requester at or after ptr, wrapping.
  function automatic int pick(input logic [N-1:0] r);
    for (int k = 0; k < N; k++) begin
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    step();
    step();
    rst_n = 1'b1;
    ptr   = 0;
  endtask

  // Runs one slot from an IDLE cycle; withdraws the winner when cnt == wd_at.
  task automatic run_slot(input int wd_at, input bit scram, output int w);
    logic [N-1:0]     eg;
    logic [CNT_W-1:0] ec;
    int               l;
    bit               ab;
    w  = pick(req);
    l  = int'(len[w*CNT_W +: CNT_W]);
    eg = N'(1) << w;
    ab = 1'b0;
    step();
    for (int k = 0; k <= l; k++) begin
      ec = CNT_W'(k);
      total++;
      if ({gnt, busy, cnt, done, abort} !== {eg, 1'b1, ec, {N{1'b0}}, 1'b0}) begin
        bad++;
        $display("FAIL run w=%0d k=%0d: got gnt=%b busy=%b cnt=%0d done=%b abort=%b, exp gnt=%b busy=1 cnt=%0d done=0 abort=0",
                 w, k, gnt, busy, cnt, done, abort, eg, ec);
      end
      if (scram) len = N*CNT_W'($urandom);
      if (k == wd_at) begin
        req[w] = 1'b0;
        ab     = 1'b1;
        break;
      end
      if (k == l) break;
      step();
    end
    step();
    total++;
    if ({gnt, busy, cnt, done, abort} !== {{N{1'b0}}, 1'b0, {CNT_W{1'b0}}, (ab ? {N{1'b0}} : eg), ab}) begin
      bad++;
      $display("FAIL done_cycle w=%0d: got gnt=%b busy=%b cnt=%0d done=%b abort=%b, exp done=%b abort=%b",
               w, gnt, busy, cnt, done, abort, (ab ? {N{1'b0}} : eg), ab);
    end
`ifndef USS_FIXED_PRIO_EN
    ptr = (w + 1) % N;
`endif
    step();
    total++;
    if ({gnt, busy, cnt, done, abort} !== '0) begin
      bad++;
      $display("FAIL idle_after w=%0d: got gnt=%b busy=%b cnt=%0d done=%b abort=%b, exp all 0",
               w, gnt, busy, cnt, done, abort);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = '0;
    len   = '0;
    ptr   = 0;
    #3;
    total++;
    if ({gnt, busy, cnt, done, abort} !== '0) begin
      bad++;
      $display("FAIL reset: got gnt=%b busy=%b cnt=%0d done=%b abort=%b, exp all 0", gnt, busy, cnt, done, abort);
    end
    step();
    rst_n = 1'b1;
    step();
    total++;
    if ({gnt, busy} !== '0) begin
      bad++;
      $display("FAIL idle_no_req: got gnt=%b busy=%b, exp 0", gnt, busy);
    end
  endtask

  task automatic test_single();
    int w;
    req = 4'b0001;
    len = {3'd0, 3'd0, 3'd0, 3'd3};
    run_slot(-1, 1'b0, w);
    req = '0;
  endtask

  task automatic test_round_robin();
    int w;
    do_reset();
    req = 4'b1111;
    for (int s = 0; s < 5; s++) begin
      len = {3'd1, 3'd1, 3'd1, 3'd1};
      run_slot(-1, 1'b0, w);
    end
    req = '0;
  endtask

  task automatic test_boundaries();
    int w;
    req = 4'b0001;
    len = {3'd7, 3'd7, 3'd7, 3'd0};
    run_slot(-1, 1'b0, w);
    req = 4'b0100;
    len = {3'd0, 3'd7, 3'd0, 3'd0};
    run_slot(-1, 1'b0, w);
    req = 4'b1000;
    len = {3'd5, 3'd0, 3'd0, 3'd0};
    run_slot(5, 1'b0, w);
    req = '0;
  endtask

  task automatic test_withdraw();
    int w;
    do_reset();
    req = 4'b1100;
    len = {3'd2, 3'd6, 3'd0, 3'd0};
    run_slot(3, 1'b1, w);
    len = {3'd2, 3'd6, 3'd0, 3'd0};
    run_slot(-1, 1'b0, w);
    req = '0;
  endtask

  task automatic test_reset_mid();
    int w;
    do_reset();
    req = 4'b0010;
    len = {3'd0, 3'd0, 3'd5, 3'd0};
    step();
    step();
    step();
    total++;
    if ({gnt, busy, cnt} !== {4'b0010, 1'b1, 3'd2}) begin
      bad++;
      $display("FAIL pre_reset: got gnt=%b busy=%b cnt=%0d, exp gnt=0010 busy=1 cnt=2", gnt, busy, cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({gnt, busy, cnt, done, abort} !== '0) begin
      bad++;
      $display("FAIL async_reset: got gnt=%b busy=%b cnt=%0d done=%b abort=%b, exp all 0", gnt, busy, cnt, done, abort);
    end
    step();
    total++;
    if ({gnt, busy, cnt, done, abort} !== '0) begin
      bad++;
      $display("FAIL reset_no_pulse: got gnt=%b busy=%b cnt=%0d done=%b abort=%b, exp all 0", gnt, busy, cnt, done, abort);
    end
    rst_n = 1'b1;
    ptr   = 0;
    req   = 4'b0110;
    len   = {3'd0, 3'd1, 3'd2, 3'd0};
    run_slot(-1, 1'b0, w);
    req = '0;
  endtask

  task automatic test_random();
    int w;
    int wd;
    do_reset();
    for (int s = 0; s < 40; s++) begin
      len = N*CNT_W'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        req = '0;
        step();
        total++;
        if ({gnt, busy, cnt, done, abort} !== '0) begin
          bad++;
          $display("FAIL idle_hold s=%0d: got gnt=%b busy=%b cnt=%0d, exp all 0", s, gnt, busy, cnt);
        end
      end
      req = N'($urandom_range(1, (1 << N) - 1));
      wd  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
      run_slot(wd, 1'b1, w);
    end
    req = '0;
  endtask

`ifdef USS_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    int w;
    do_reset();
    req = 4'b0011;
    for (int s = 0; s < 6; s++) begin
      len = '0;
      run_slot(-1, 1'b0, w);
    end
    req = '0;
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_boundaries();
    test_withdraw();
    test_reset_mid();
    test_random();
`ifdef USS_FIXED_PRIO_EN
    test_fixed_prio();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
